// File: rtl/spi_tx_feeder_if.sv
// spi_tx_feeder_if: host and SPI-master side signals of the TX feeder.
// master = host/SPI side that drives requests, slave = the feeder.
interface spi_tx_feeder_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          spi_busy;
    logic          spi_valid;
    logic [7:0]    data;
    logic          spi_start;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    sent_cnt;

    modport master (
        output wr_en, wr_data, flush, spi_busy, spi_valid,
        input  data, spi_start, full, empty, count, overflow, sent_cnt
    );

    modport slave (
        input  wr_en, wr_data, flush, spi_busy, spi_valid,
        output data, spi_start, full, empty, count, overflow, sent_cnt
    );
endinterface

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: byte FIFO that feeds an SPI master one byte at a time.
// Head byte is latched into data on the IDLE->LOAD edge, popped at LOAD exit.
module spi_tx_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           spi_clk,
    input  logic           reset,
    spi_tx_feeder_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    data_q;
    logic [7:0]    sent_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          load_go;
    logic          done;

    assign bus.count     = count;
    assign bus.full      = (count == FULL_CNT);
    assign bus.empty     = (count == '0);
    assign bus.data      = data_q;
    assign bus.spi_start = (state == LOAD);
    assign bus.overflow  = ovf_q;
    assign bus.sent_cnt  = sent_q;

    // A flushed cycle ignores the write; a full FIFO rejects it.
    assign push    = bus.wr_en & ~bus.full & ~bus.flush;
    // Guard covers a flush that landed while entering LOAD.
    assign pop     = (state == LOAD) & ~bus.empty;
    assign load_go = (state == IDLE) & ~bus.empty & ~bus.spi_busy;
    assign done    = bus.spi_valid &
                     ((state == WAIT_BUSY) | (state == WAIT_DONE));

    // Transfer sequencing toward the SPI master.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (load_go) state_nx = LOAD;
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.spi_valid)     state_nx = IDLE;
                else if (bus.spi_busy) state_nx = WAIT_DONE;
            end
            WAIT_DONE: if (bus.spi_valid) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care after reset.
    always_ff @(posedge spi_clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers and occupancy, with synchronous flush.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // State, presented byte, completion counter and overflow pulse.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data_q <= 8'h00;
            sent_q <= 8'h00;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nx;
            ovf_q <= bus.wr_en & bus.full & ~bus.flush;
            if (load_go) data_q <= mem[rd_ptr];
            if (done)    sent_q <= sent_q + 8'd1;
        end
    end

endmodule

// File: doc/spi_tx_feeder.md
SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving FIFO entries; it is a power of two, minimum 2.
REQ-002 The block SHALL have parameter AW, default 3, giving the pointer width, equal to log2(DEPTH).
REQ-003 Port spi_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wr_en, input, 1 bit: host write strobe.
REQ-006 Port wr_data, input, 8 bits: host byte to queue.
REQ-007 Port flush, input, 1 bit: synchronous FIFO clear request.
REQ-008 Port spi_busy, input, 1 bit: busy flag from the SPI master.
REQ-009 Port spi_valid, input, 1 bit: one-cycle byte-complete pulse from the SPI master.
REQ-010 Port data, output, 8 bits: byte presented to the SPI master.
REQ-011 Port spi_start, output, 1 bit: one-cycle transfer request to the SPI master.
REQ-012 Port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 Port empty, output, 1 bit: FIFO holds 0 entries.
REQ-014 Port count, output, AW+1 bits: current FIFO occupancy.
REQ-015 Port overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-016 Port sent_cnt, output, 8 bits: count of completed bytes.

Function
REQ-017 The FIFO SHALL be circular, with AW-bit read and write pointers wrapping DEPTH-1 to 0, and count ranging 0..DEPTH.
REQ-018 full and empty SHALL be decoded from the registered count.
- A write in the same cycle as a pop while full is rejected.
REQ-019 A write SHALL be accepted when wr_en=1 and full=0.
- wr_data is stored at the write pointer.
- The write pointer increments and count increments, unless a pop occurs in the same cycle, in which case count is unchanged.
REQ-020 A write with wr_en=1 and full=1 SHALL be dropped and SHALL pulse overflow for exactly one cycle; FIFO contents are unchanged.
REQ-021 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-022 Transitions from IDLE: go to LOAD when empty=0 and spi_busy=0; otherwise hold.
REQ-023 In LOAD the block SHALL pop the head entry into data, assert spi_start for that cycle only, decrement count (net of a simultaneous write), and go to WAIT_BUSY.
REQ-024 Transitions from WAIT_BUSY: go to WAIT_DONE on spi_busy=1; go directly to IDLE if spi_valid=1 arrives first. In the spi_valid case sent_cnt increments.
REQ-025 Transitions from WAIT_DONE: on spi_valid=1, increment sent_cnt and go to IDLE; otherwise hold.
REQ-026 data SHALL remain stable from LOAD until the next LOAD.
REQ-027 Latency: the first spi_start SHALL occur 2 cycles after an accepted write into an empty FIFO, given spi_busy=0.
- Cycle 1: write.
- Cycle 2: IDLE sees empty=0 and moves to LOAD.
REQ-028 sent_cnt SHALL wrap from 255 to 0 without a flag.
REQ-029 flush=1 SHALL reset both pointers and count to 0 on the next edge, and SHALL ignore a simultaneous write.
- A byte already in LOAD, WAIT_BUSY or WAIT_DONE completes normally.
- data and sent_cnt are unchanged.
REQ-030 spi_valid pulses received in IDLE or LOAD SHALL be ignored.

Reset
REQ-031 While reset=0 the block SHALL immediately force state=IDLE, pointers=0, count=0, data=8'h00, spi_start=0, overflow=0, sent_cnt=0, full=0 and empty=1; FIFO storage need not clear.
REQ-032 Reset asserted mid-transfer SHALL abandon the byte in flight, with no sent_cnt increment.
REQ-033 Reset deassertion SHALL take effect on the next spi_clk edge.

Verification
REQ-034 Single byte:
- Stimulus: write 8'hA5 with spi_busy=0, then the master model raises busy for 16 cycles and then pulses valid.
- Response: spi_start 2 cycles after the write, data=8'hA5, sent_cnt=1, empty=1.
REQ-035 Fill and overflow:
- Stimulus: 9 consecutive writes 8'h01..8'h09 while spi_busy=1.
- Response: full=1, count=8, overflow pulses once on the 9th write, 8'h09 is lost.
REQ-036 Order and wrap:
- Stimulus: 12 bytes 8'h10..8'h1B streamed with interleaved completions.
- Response: data sequence is exactly 8'h10..8'h1B, pointers wrap, sent_cnt=12.
REQ-037 Simultaneous write and pop:
- Stimulus: write in the LOAD cycle with count=3.
- Response: count stays 3; write while full during LOAD is rejected with overflow.
REQ-038 Flush mid-transfer:
- Stimulus: 4 queued, first in WAIT_DONE, assert flush, then pulse valid.
- Response: count=0, sent_cnt=1, FSM returns to IDLE, no further spi_start.
REQ-039 Reset mid-transfer:
- Stimulus: reset=0 while in WAIT_DONE with count=2.
- Response: all outputs at reset values immediately; no spi_start after release until a new write.
